// File: rtl/bus_ctrl_pkg.sv
// Shared types and helpers for the destination-side bus transfer sequencer.
// Holds the FSM state encoding, the queued command layout and the load-strobe decode.
package bus_ctrl_pkg;

   localparam int BUS_SEL_W = 3;
   localparam int NUM_PORTS = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LOAD   = 2'd2
   } state_t;

   typedef struct packed {
      logic [BUS_SEL_W-1:0] src;
      logic [BUS_SEL_W-1:0] dst;
   } cmd_t;

   function automatic logic [NUM_PORTS-1:0] onehot8(input logic [BUS_SEL_W-1:0] idx);
      logic [NUM_PORTS-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command queue; the head entry is visible on rdata while not empty.
// Pointers wrap naturally because DEPTH is a power of two.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [W-1:0]           wdata,
   output logic [W-1:0]           rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   // Full and empty come from the registered count, so a push into an empty
   // queue can never be popped in the same cycle, and a full queue refuses pushes
   // even when a pop is happening.
   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign count   = count_reg;
   assign rdata   = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Sequences queued {src, dst} bus transfers: select the source, let the bus settle,
// strobe the destination load enable, then capture the transferred value and pulse done.
module bus_transfer_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int BUS_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [BUS_SEL_W-1:0] cmd_src,
   input  logic [BUS_SEL_W-1:0] cmd_dst,
   output logic [BUS_SEL_W-1:0] bus_sel,
   input  logic [BUS_W-1:0]     bus_data,
   output logic [NUM_PORTS-1:0] load_en,
   output logic [BUS_W-1:0]     capture,
   output logic                 done,
   output logic                 busy
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_t               state_reg;
   state_t               state_next;
   logic [BUS_SEL_W-1:0] cur_dst_reg;
   logic [BUS_SEL_W-1:0] cur_dst_next;
   logic [BUS_SEL_W-1:0] bus_sel_reg;
   logic [BUS_SEL_W-1:0] bus_sel_next;
   logic [NUM_PORTS-1:0] load_en_reg;
   logic [NUM_PORTS-1:0] load_en_next;
   logic [BUS_W-1:0]     capture_reg;
   logic [BUS_W-1:0]     capture_next;
   logic                 done_reg;
   logic                 done_next;

   cmd_t                 push_cmd;
   cmd_t                 head_cmd;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CW-1:0]        fifo_count;

   assign push_cmd.src = cmd_src;
   assign push_cmd.dst = cmd_dst;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(cmd_t))
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .pop   (fifo_pop),
      .wdata (push_cmd),
      .rdata (head_cmd),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign cmd_ready = !fifo_full;
   assign busy      = (state_reg != IDLE) || (fifo_count != '0);
   assign bus_sel   = bus_sel_reg;
   assign load_en   = load_en_reg;
   assign capture   = capture_reg;
   assign done      = done_reg;

   // load_en is registered on entry to LOAD, so it is high exactly for the LOAD cycle.
   always_comb begin
      state_next   = state_reg;
      cur_dst_next = cur_dst_reg;
      bus_sel_next = bus_sel_reg;
      load_en_next = '0;
      capture_next = capture_reg;
      done_next    = 1'b0;
      fifo_pop     = 1'b0;

      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               cur_dst_next = head_cmd.dst;
               bus_sel_next = head_cmd.src;
               state_next   = SETTLE;
            end
         end
         SETTLE: begin
            load_en_next = onehot8(cur_dst_reg);
            state_next   = LOAD;
         end
         LOAD: begin
            capture_next = bus_data;
            done_next    = 1'b1;
            if (!fifo_empty) begin
               fifo_pop     = 1'b1;
               cur_dst_next = head_cmd.dst;
               bus_sel_next = head_cmd.src;
               state_next   = SETTLE;
            end else begin
               state_next   = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cur_dst_reg <= '0;
         bus_sel_reg <= '0;
         load_en_reg <= '0;
         capture_reg <= '0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cur_dst_reg <= cur_dst_next;
         bus_sel_reg <= bus_sel_next;
         load_en_reg <= load_en_next;
         capture_reg <= capture_next;
         done_reg    <= done_next;
      end
   end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Scoreboard bench for bus_transfer_ctrl: stimulus pushes expected transfers,
// a negedge monitor pops and compares on every load strobe and done pulse.
module tb_bus_transfer_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [2:0] cmd_src = 3'd0;
   logic [2:0] cmd_dst = 3'd0;
   logic       cmd_ready;
   logic [2:0] bus_sel;
   logic [7:0] bus_data;
   logic [7:0] load_en;
   logic [7:0] capture;
   logic       done;
   logic       busy;

   // Register-file contents seen through the bus mux, one distinct value per source.
   localparam logic [7:0] MUX_VAL [8] = '{8'h0F, 8'h1E, 8'h2D, 8'hA5, 8'h4B, 8'h5A, 8'h69, 8'hC3};
   localparam logic [2:0] WSRC [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2, 3'd1};
   localparam logic [2:0] WDST [10] = '{3'd1, 3'd2, 3'd4, 3'd6, 3'd0, 3'd3, 3'd7, 3'd5, 3'd2, 3'd6};
   localparam int         WGAP [10] = '{0, 1, 0, 2, 0, 0, 3, 1, 0, 0};

   typedef struct packed {
      logic [2:0] src;
      logic [2:0] dst;
   } exp_t;

   exp_t       load_q[$];
   logic [7:0] data_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int last_done_cyc = -1;
   bit gap_chk = 1'b0;
   bit saw_full = 1'b0;

   assign bus_data = MUX_VAL[bus_sel];

   bus_transfer_ctrl #(
      .DEPTH (4),
      .BUS_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_src   (cmd_src),
      .cmd_dst   (cmd_dst),
      .bus_sel   (bus_sel),
      .bus_data  (bus_data),
      .load_en   (load_en),
      .capture   (capture),
      .done      (done),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic sb_push(input logic [2:0] s, input logic [2:0] d);
      exp_t e;
      e.src = s;
      e.dst = d;
      load_q.push_back(e);
      data_q.push_back(MUX_VAL[s]);
   endtask

   // Offers one command and returns #1 after the accepting edge; cmd_valid is left high.
   task automatic send(input logic [2:0] s, input logic [2:0] d);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_src   = s;
      cmd_dst   = d;
      while (!cmd_ready && n < 100) begin
         saw_full = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      if (!cmd_ready) begin
         check("send_timeout", {31'd0, cmd_ready}, 32'd1);
      end else begin
         sb_push(s, d);
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      @(negedge clk); #1;
      check({tag, "_loadq_left"}, load_q.size(), 32'd0);
      check({tag, "_dataq_left"}, data_q.size(), 32'd0);
   endtask

   // Cycle-exact single transfer from an idle, empty controller.
   task automatic timed_single(input logic [2:0] s, input logic [2:0] d, input logic [7:0] want_cap,
                               input logic [7:0] want_le, input logic [2:0] prev_sel);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_src   = s;
      cmd_dst   = d;
      check("single_ready", {31'd0, cmd_ready}, 32'd1);
      sb_push(s, d);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check("e0_sel_nopop", bus_sel, prev_sel);
      check("e0_load", load_en, 8'h00);
      check("e0_busy", {31'd0, busy}, 32'd1);
      check("e0_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("e1_settle_sel", bus_sel, s);
      check("e1_settle_load", load_en, 8'h00);
      @(negedge clk);
      check("e2_load_sel", bus_sel, s);
      check("e2_load_en", load_en, want_le);
      check("e2_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("e3_done", {31'd0, done}, 32'd1);
      check("e3_capture", capture, want_cap);
      check("e3_load", load_en, 8'h00);
      @(negedge clk);
      check("e4_done", {31'd0, done}, 32'd0);
      check("e4_busy", {31'd0, busy}, 32'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [7:0] d;
      if (rst_n) begin
         if (load_en != 8'h00) begin
            if (load_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL load_unexpected got load_en=%0h want no strobe", load_en);
            end else begin
               e = load_q.pop_front();
               check("mon_load_sel", bus_sel, e.src);
               check("mon_load_en", load_en, 8'h01 << e.dst);
            end
         end
         if (done) begin
            if (data_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL done_unexpected got capture=%0h want no done", capture);
            end else begin
               d = data_q.pop_front();
               check("mon_capture", capture, d);
            end
            if (gap_chk && last_done_cyc >= 0) begin
               check("mon_done_gap", cyc - last_done_cyc, 32'd2);
            end
            last_done_cyc = cyc;
            done_cnt++;
         end
      end
   end

   initial begin : stimulus
      int base;

      #3;
      check("rst_bus_sel", bus_sel, 3'd0);
      check("rst_load_en", load_en, 8'h00);
      check("rst_capture", capture, 8'h00);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      #19;
      rst_n = 1'b1;

      timed_single(3'd3, 3'd5, 8'hA5, 8'h20, 3'd0);
      wait_idle("single");

      timed_single(3'd7, 3'd7, 8'hC3, 8'h80, 3'd3);
      wait_idle("self");

      // Burst: eight commands offered back to back, enough to fill the queue.
      @(posedge clk); #1;
      base          = done_cnt;
      last_done_cyc = -1;
      gap_chk       = 1'b1;
      saw_full      = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(3'(i), 3'(7 - i));
      end
      cmd_valid = 1'b0;
      wait_idle("burst");
      gap_chk = 1'b0;
      check("burst_full_seen", {31'd0, saw_full}, 32'd1);
      check("burst_done_count", done_cnt - base, 32'd8);

      // Interleaved pushes and pops so the pointers wrap several times.
      base = done_cnt;
      for (int i = 0; i < 10; i++) begin
         repeat (WGAP[i]) begin
            @(posedge clk); #1;
         end
         send(WSRC[i], WDST[i]);
         cmd_valid = 1'b0;
      end
      wait_idle("wrap");
      check("wrap_done_count", done_cnt - base, 32'd10);

      // Reset during LOAD with two commands still queued.
      @(posedge clk); #1;
      send(3'd1, 3'd2);
      send(3'd2, 3'd3);
      send(3'd4, 3'd5);
      cmd_valid = 1'b0;
      check("rst_pre_load", load_en, 8'h04);
      #2;
      rst_n = 1'b0;
      load_q.delete();
      data_q.delete();
      #1;
      check("rst_async_load", load_en, 8'h00);
      check("rst_async_done", {31'd0, done}, 32'd0);
      check("rst_async_busy", {31'd0, busy}, 32'd0);
      check("rst_async_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_async_sel", bus_sel, 3'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("rst_post_busy", {31'd0, busy}, 32'd0);
         check("rst_post_done", {31'd0, done}, 32'd0);
         check("rst_post_ready", {31'd0, cmd_ready}, 32'd1);
      end

      timed_single(3'd4, 3'd0, 8'h4B, 8'h01, 3'd0);
      wait_idle("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
